// File: rtl/msg_tx_pkg.sv
// Shared types and constants for the message serial transmit stage.
// Imported by the top level and its testbench.
package msg_tx_pkg;

    typedef enum logic [1:0] {
        Idle  = 2'd0,
        Start = 2'd1,
        Data  = 2'd2,
        Stop  = 2'd3
    } txState_t;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DATA_BITS            = 8;

endpackage

// File: rtl/msg_p2s_uart_tx_bit_timer.sv
// Bit-period timer: counts clocks within one serial bit while enabled.
// BitDone pulses on the last clock of each bit period.
module bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic Clock,
    input  logic Clear,
    input  logic Enable,
    output logic BitDone
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            count <= '0;
        end else if (!Enable || BitDone) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign BitDone = Enable && (count == LAST);

endmodule

// File: rtl/msg_p2s_uart_tx.sv
// Parallel-to-serial 8N1 transmitter with a one-byte holding register
// in front of the shifter so consecutive frames run back-to-back.
module msg_p2s_uart_tx
    import msg_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic       Clock,
    input  logic       Clear,
    input  logic       Load,
    input  logic [7:0] DataIn,
    output logic       Empty,
    output logic       Busy,
    output logic       Overrun,
    output logic       SerialOut
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = (STOP_BITS == 2);

    txState_t   state;
    txState_t   stateNext;
    logic [7:0] hold;
    logic [7:0] holdNext;
    logic [7:0] shifter;
    logic [7:0] shifterNext;
    logic [2:0] bitCount;
    logic [2:0] bitCountNext;
    logic       stopCount;
    logic       stopCountNext;
    logic       emptyNext;
    logic       overrunNext;
    logic       lineNext;
    logic       frameLoad;
    logic       bitDone;
    logic       holdValid;

    assign holdValid = ~Empty;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) timer (
        .Clock  (Clock),
        .Clear  (Clear),
        .Enable (state != Idle),
        .BitDone(bitDone)
    );

    always_comb begin
        stateNext     = state;
        holdNext      = hold;
        shifterNext   = shifter;
        bitCountNext  = bitCount;
        stopCountNext = stopCount;
        emptyNext     = Empty;
        overrunNext   = Overrun;
        lineNext      = SerialOut;
        frameLoad     = 1'b0;

        unique case (state)
            Idle: begin
                lineNext  = 1'b1;
                frameLoad = holdValid;
            end
            Start: begin
                if (bitDone) begin
                    stateNext = Data;
                    lineNext  = shifter[0];
                end
            end
            Data: begin
                if (bitDone) begin
                    if (bitCount == LAST_BIT) begin
                        stateNext    = Stop;
                        lineNext     = 1'b1;
                        bitCountNext = '0;
                    end else begin
                        shifterNext  = shifter >> 1;
                        lineNext     = shifter[1];
                        bitCountNext = bitCount + 3'd1;
                    end
                end
            end
            Stop: begin
                if (bitDone) begin
                    if (stopCount != LAST_STOP) begin
                        stopCountNext = 1'b1;
                    end else begin
                        stopCountNext = 1'b0;
                        frameLoad     = holdValid;
                        if (!holdValid) begin
                            stateNext = Idle;
                        end
                    end
                end
            end
            default: begin
                stateNext = Idle;
                lineNext  = 1'b1;
            end
        endcase

        // Hand the pending byte to the shifter; start bit goes out next cycle.
        if (frameLoad) begin
            shifterNext  = hold;
            emptyNext    = 1'b1;
            stateNext    = Start;
            lineNext     = 1'b0;
            bitCountNext = '0;
        end

        if (Load) begin
            if (Empty) begin
                holdNext  = DataIn;
                emptyNext = 1'b0;
            end else begin
                overrunNext = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state     <= Idle;
            hold      <= '0;
            shifter   <= '0;
            bitCount  <= '0;
            stopCount <= 1'b0;
            Empty     <= 1'b1;
            Busy      <= 1'b0;
            Overrun   <= 1'b0;
            SerialOut <= 1'b1;
        end else begin
            state     <= stateNext;
            hold      <= holdNext;
            shifter   <= shifterNext;
            bitCount  <= bitCountNext;
            stopCount <= stopCountNext;
            Empty     <= emptyNext;
            Busy      <= (stateNext != Idle);
            Overrun   <= overrunNext;
            SerialOut <= lineNext;
        end
    end

endmodule

// File: tb/tb_msg_p2s_uart_tx.sv
// Bench for msg_p2s_uart_tx: frame-schedule model, per-cycle compare,
// an independent line receiver and hand-computed literal checks.
`timescale 1ns/1ps
module tb_msg_p2s_uart_tx;

    logic       clk = 1'b0;
    logic       clr;
    logic       load0, load1;
    logic [7:0] data0, data1;
    logic       empty0, busy0, ovr0, line0;
    logic       empty1, busy1, ovr1, line1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    msg_p2s_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut0 (
        .Clock(clk), .Clear(clr), .Load(load0), .DataIn(data0),
        .Empty(empty0), .Busy(busy0), .Overrun(ovr0), .SerialOut(line0)
    );

    msg_p2s_uart_tx #(.CLKS_PER_BIT(2), .STOP_BITS(2)) dut1 (
        .Clock(clk), .Clear(clr), .Load(load1), .DataIn(data1),
        .Empty(empty1), .Busy(busy1), .Overrun(ovr1), .SerialOut(line1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted byte gets a frame start edge s = max(load+1, prev end).
    typedef struct {
        int         k;
        int         s;
        logic [7:0] d;
    } frame_t;

    frame_t fq[$];
    int n = 0;
    int cpb[2]       = '{4, 2};
    int flen[2]      = '{(10 + 1 - 1) * 4, (10 + 2 - 1) * 2};
    int lastEnd[2]   = '{0, 0};
    int holdUntil[2] = '{0, 0};
    bit mEmpty[2]    = '{1, 1};
    bit mBusy[2]     = '{0, 0};
    bit mOvr[2]      = '{0, 0};
    bit mLine[2]     = '{1, 1};

    task automatic modelStep(input int k, input logic ld, input logic [7:0] d);
        int s;
        int b;
        frame_t f;
        if (ld) begin
            if (mEmpty[k]) begin
                s = (n + 1 > lastEnd[k]) ? n + 1 : lastEnd[k];
                lastEnd[k] = s + flen[k];
                holdUntil[k] = s;
                f.k = k;
                f.s = s;
                f.d = d;
                fq.push_back(f);
            end else begin
                mOvr[k] = 1'b1;
            end
        end
        for (int i = fq.size() - 1; i >= 0; i--) begin
            if (fq[i].k == k && n >= fq[i].s + flen[k]) fq.delete(i);
        end
        mEmpty[k] = (n >= holdUntil[k]);
        mBusy[k] = 1'b0;
        mLine[k] = 1'b1;
        foreach (fq[i]) begin
            if (fq[i].k == k && n >= fq[i].s) begin
                b = (n - fq[i].s) / cpb[k];
                mBusy[k] = 1'b1;
                if (b == 0) mLine[k] = 1'b0;
                else if (b <= 8) mLine[k] = fq[i].d[b - 1];
            end
        end
    endtask

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            n = 0;
            fq.delete();
            for (int k = 0; k < 2; k++) begin
                lastEnd[k] = 0;
                holdUntil[k] = 0;
                mEmpty[k] = 1'b1;
                mBusy[k] = 1'b0;
                mOvr[k] = 1'b0;
                mLine[k] = 1'b1;
            end
        end else begin
            n = n + 1;
            modelStep(0, load0, data0);
            modelStep(1, load1, data1);
        end
    end

    always @(negedge clk) begin
        if (!clr) begin
            chk("empty0", empty0, mEmpty[0]);
            chk("busy0", busy0, mBusy[0]);
            chk("overrun0", ovr0, mOvr[0]);
            chk("line0", line0, mLine[0]);
            chk("empty1", empty1, mEmpty[1]);
            chk("busy1", busy1, mBusy[1]);
            chk("overrun1", ovr1, mOvr[1]);
            chk("line1", line1, mLine[1]);
        end
    end

    // Receiver for dut0 (4 clocks/bit): samples each bit mid-period.
    logic [7:0] rxByte;
    bit         rxBad;
    logic [7:0] rxQ[$];

    always begin
        @(negedge clk);
        if (!clr && line0 === 1'b0) begin
            rxBad = 1'b0;
            rxByte = '0;
            for (int i = 1; i <= 38; i++) begin
                @(negedge clk);
                if (clr) rxBad = 1'b1;
                if (i >= 6 && i <= 34 && (i % 4) == 2) rxByte[3'((i - 6) / 4)] = line0;
            end
            if (line0 !== 1'b1) rxBad = 1'b1;
            if (!rxBad) rxQ.push_back(rxByte);
        end
    end

    logic capLine[128];
    logic capBusy[128];
    logic capEmpty[128];

    task automatic capture(input int k, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            capLine[i]  = (k == 0) ? line0 : line1;
            capBusy[i]  = (k == 0) ? busy0 : busy1;
            capEmpty[i] = (k == 0) ? empty0 : empty1;
            @(negedge clk);
        end
    endtask

    task automatic waitIdle0(input int maxc);
        int c = 0;
        while (busy0 !== 1'b0 && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk("idle0 wait", busy0, 0);
    endtask

    task automatic waitEmpty0(input int maxc);
        int c = 0;
        while (empty0 !== 1'b1 && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk("empty0 wait", empty0, 1);
    endtask

    task automatic send0(input logic [7:0] d);
        data0 = d;
        load0 = 1'b1;
        @(negedge clk);
        load0 = 1'b0;
    endtask

    task automatic expectRx(input string name, input logic [7:0] d);
        chk({name, " rx present"}, (rxQ.size() > 0), 1);
        if (rxQ.size() > 0) chk({name, " rx byte"}, rxQ.pop_front(), d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [9:0]  seq10;
        logic [21:0] seq22;

        clr = 1'b1;
        load0 = 1'b0;
        load1 = 1'b0;
        data0 = '0;
        data1 = '0;
        #1;
        chk("reset line", line0, 1);
        chk("reset empty", empty0, 1);
        chk("reset busy", busy0, 0);
        chk("reset overrun", ovr0, 0);
        repeat (3) @(negedge clk);
        clr = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte 0xA5
        send0(8'hA5);
        capture(0, 45);
        cnt = 0;
        for (int i = 0; i < 45; i++) cnt += capEmpty[i] ? 0 : 1;
        chk("A5 empty low cycles", cnt, 1);
        chk("A5 empty after load", capEmpty[0], 0);
        cnt = 0;
        for (int i = 0; i < 45; i++) cnt += capBusy[i] ? 1 : 0;
        chk("A5 busy cycles", cnt, 40);
        chk("A5 busy drop", capBusy[41], 0);
        for (int b = 0; b < 10; b++) seq10[b] = capLine[2 + 4 * b];
        chk("A5 bit sequence", seq10, 10'b1101001010);
        expectRx("A5", 8'hA5);

        // Back-to-back 0x01, 0xFF
        send0(8'h01);
        waitEmpty0(10);
        send0(8'hFF);
        capture(0, 100);
        cnt = 0;
        for (int i = 0; i < 100; i++) cnt += capBusy[i] ? 1 : 0;
        chk("b2b busy cycles", cnt, 79);
        chk("b2b busy drop", capBusy[79], 0);
        chk("b2b last stop", capLine[38], 1);
        chk("b2b start first", capLine[39], 0);
        chk("b2b start last", capLine[42], 0);
        chk("b2b FF bit0", capLine[43], 1);
        expectRx("b2b first", 8'h01);
        expectRx("b2b second", 8'hFF);

        // Overrun
        waitIdle0(100);
        send0(8'h3C);
        waitEmpty0(10);
        send0(8'h55);
        chk("ovr hold full", empty0, 0);
        chk("ovr before", ovr0, 0);
        send0(8'h77);
        chk("ovr set", ovr0, 1);
        chk("ovr hold kept", empty0, 0);
        waitIdle0(200);
        repeat (5) @(negedge clk);
        chk("ovr sticky", ovr0, 1);
        expectRx("ovr first", 8'h3C);
        expectRx("ovr second", 8'h55);
        chk("ovr no third byte", rxQ.size(), 0);

        // Load in the last stop cycle with nothing pending
        send0(8'h00);
        repeat (40) @(negedge clk);
        chk("edge last stop busy", busy0, 1);
        chk("edge last stop line", line0, 1);
        chk("edge last stop empty", empty0, 1);
        send0(8'h80);
        chk("edge gap busy", busy0, 0);
        chk("edge gap line", line0, 1);
        chk("edge gap empty", empty0, 0);
        @(negedge clk);
        chk("edge start busy", busy0, 1);
        chk("edge start line", line0, 0);
        waitIdle0(100);
        repeat (5) @(negedge clk);
        expectRx("edge first", 8'h00);
        expectRx("edge second", 8'h80);

        // Clear mid-frame
        send0(8'h5A);
        @(negedge clk);
        chk("clr pre line", line0, 0);
        #2;
        clr = 1'b1;
        #1;
        chk("clr line", line0, 1);
        chk("clr empty", empty0, 1);
        chk("clr busy", busy0, 0);
        chk("clr overrun", ovr0, 0);
        @(negedge clk);
        clr = 1'b0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            cnt += (line0 === 1'b1 && busy0 === 1'b0) ? 1 : 0;
        end
        chk("clr line idle cycles", cnt, 50);
        chk("clr no rx byte", rxQ.size(), 0);

        // Two stop bits, 2 clocks/bit
        data1 = 8'h0F;
        load1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
        capture(1, 26);
        cnt = 0;
        for (int i = 0; i < 26; i++) cnt += capBusy[i] ? 1 : 0;
        chk("sb2 busy cycles", cnt, 22);
        chk("sb2 busy last", capBusy[22], 1);
        chk("sb2 busy drop", capBusy[23], 0);
        for (int i = 0; i < 22; i++) seq22[i] = capLine[i + 1];
        chk("sb2 line sequence", seq22, 22'h3C03FC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msg_p2s_uart_tx.md
Name: msg_p2s_uart_tx

Overview:
Parallel-to-serial stage directly downstream of the message sender. It accepts one byte per Load pulse into a holding register and reports holding-register vacancy on Empty, which the sender polls before each load. It shifts each byte out as an 8N1 asynchronous serial frame (start bit, data LSB first, stop bit(s)) on the line to the Arduino. The holding register double-buffers the shifter, so consecutive bytes go out back-to-back with no idle gap.

Parameters:
CLKS_PER_BIT, 868, Clock cycles per serial bit (100 MHz / 115200 baud); legal range ≥2.
STOP_BITS, 1, Number of stop bits (1 or 2).

Ports:
Clock  input  1  system clock; all state changes on rising edge
Clear  input  1  asynchronous, active-high reset
Load  input  1  one-cycle strobe: capture DataIn into holding register
DataIn  input  8  byte to send (sender's OutputByte)
Empty  output  1  registered; 1 = holding register vacant, Load will be accepted
Busy  output  1  registered; 1 = frame in progress (state ≠ Idle)
Overrun  output  1  sticky; Load received while Empty=0
SerialOut  output  1  registered serial line, idles high

Behaviour:
- Reset (Clear=1, async): SerialOut=1, Empty=1, Busy=0, Overrun=0, state=Idle, bit/clock counters=0, holding and shift registers=0. Reset mid-frame truncates the frame; the line goes high immediately.
- Holding register (hold, holdValid); Empty = ~holdValid, registered.
- Load with Empty=1: DataIn is captured at that edge, and Empty reads 0 from the next cycle.
- Load with Empty=0: the byte is dropped, hold is unchanged, and Overrun is set to 1. Overrun clears only on Clear.
- The sender re-polls Empty no sooner than 3 cycles after Load. Empty must already be 0 in the cycle after Load.
- States: Idle, Start, Data, Stop.
- Idle and holdValid=1:
  - At the next edge: shifter←hold, holdValid←0 (Empty=1), state←Start, SerialOut←0.
  - Latency from the Load edge to the start-bit edge is 1 clock when Idle.
- Start: SerialOut=0 for CLKS_PER_BIT cycles, then state←Data, SerialOut←shifter[0].
- Data: each bit is held for CLKS_PER_BIT cycles, LSB first. The shifter shifts right and bitCount increments. After bit 7, state←Stop and SerialOut←1.
- Stop: SerialOut=1 for STOP_BITS×CLKS_PER_BIT cycles. At the final cycle:
  - If holdValid=1: reload the shifter from hold, clear holdValid, state←Start, SerialOut←0. This gives zero-gap back-to-back frames.
  - Otherwise: state←Idle.
- Load in the same cycle as the end of Stop while holdValid=0: the byte is captured that edge, no reload occurs, state goes to Idle, and the frame starts 1 clock later. This produces one clock of extra idle high.
- Load is accepted in any state, including mid-frame, whenever Empty=1.
- Bit-period counter:
  - Width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Held at 0 in Idle.
- bitCount: 3 bits (0..7), plus a stop-bit counter when STOP_BITS=2.
- Busy=1 in Start/Data/Stop. It drops the cycle after the final stop-bit cycle unless another frame follows.
- Frame length: (10 + STOP_BITS − 1) × CLKS_PER_BIT clocks.

Decomposition:
- Package msg_tx_pkg:
  - state enum (Idle=0, Start=1, Data=2, Stop=3), 2-bit encoding
  - constants DEFAULT_CLKS_PER_BIT=868, DATA_BITS=8
- One sub-module, bit_timer: CLKS_PER_BIT-parameterised counter with enable and async Clear. It outputs a one-cycle BitDone pulse on the last cycle of each bit period.
- The top level holds the holding register, shifter, FSM and output registers.

Test Plan:
- Reset and idle: assert Clear mid-frame (CLKS_PER_BIT=4) → SerialOut=1, Empty=1, Busy=0, Overrun=0 without waiting for a clock edge; the line stays high 50 cycles after release.
- Single byte: Load 0xA5 from Idle, CLKS_PER_BIT=4 → Empty=0 for exactly 1 cycle; SerialOut sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks, 40 clocks total; Busy then drops.
- Back-to-back: Load 0x01, then Load 0xFF as soon as Empty=1 → second start bit begins the clock after the first stop bit ends (no gap); 80 clocks total.
- Overrun: Load 0x3C, then Load 0x55 and 0x77 while Empty=0 → 0x77 is dropped and Overrun=1 (sticky); only 0x3C and 0x55 appear on the line.
- Boundary: Load 0x80 in the final stop-bit cycle of a 0x00 frame with holdValid=0 → exactly 1 extra idle-high clock, then a correct 0x80 frame.
- STOP_BITS=2, CLKS_PER_BIT=2: Load 0x0F → stop-high lasts 4 clocks; frame is 22 clocks.
